tlb_entry_alloc: RTL

- Allocates TLB entries for a 32-entry fully associative TLB and sits directly upstream of the TLB write port.
- Keeps a per-entry valid vector and serves TLBFILL allocation requests.
- Picks the lowest-indexed invalid entry (priority-select, then 32-to-5 encode). When every entry is valid, it picks a round-robin victim.
- Holds one outstanding reservation until the write-back stage commits or cancels it. Also tracks TLBWR writes and INVTLB invalidations.

---
 rtl/tlb_entry_alloc_if.sv | 34 +++
 rtl/tlb_entry_alloc.sv | 118 +++++++++++
 2 files changed

// File: rtl/tlb_entry_alloc_if.sv
// Requester-side bundle for the TLB entry allocator: fill handshake,
// TLBWR/INVTLB maintenance inputs and the valid-bit status outputs.
interface tlb_entry_alloc_if #(
  parameter int ENTRY_NUM = 32,
  parameter int IDX_W     = 5
);
  logic                 alloc_req;
  logic                 alloc_gnt;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_from_free;
  logic                 alloc_commit;
  logic                 alloc_cancel;
  logic                 busy;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic                 wr_e;
  logic                 inv_en;
  logic [IDX_W-1:0]     inv_idx;
  logic                 inv_all;
  logic [ENTRY_NUM-1:0] valid_vec;
  logic [IDX_W:0]       free_cnt;

  modport master (
    output alloc_req, alloc_commit, alloc_cancel,
    output wr_en, wr_idx, wr_e, inv_en, inv_idx, inv_all,
    input  alloc_gnt, alloc_idx, alloc_from_free, busy, valid_vec, free_cnt
  );

  modport slave (
    input  alloc_req, alloc_commit, alloc_cancel,
    input  wr_en, wr_idx, wr_e, inv_en, inv_idx, inv_all,
    output alloc_gnt, alloc_idx, alloc_from_free, busy, valid_vec, free_cnt
  );
endinterface

// File: rtl/tlb_entry_alloc.sv
// Fill-entry allocator for a fully associative TLB: lowest free entry first,
// round-robin victim when full, one outstanding reservation at a time.
module tlb_entry_alloc #(
  parameter int ENTRY_NUM = 32,
  parameter int IDX_W     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  tlb_entry_alloc_if.slave       bus
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ENTRY_NUM-1:0] r_valid;
  logic [ENTRY_NUM-1:0] w_valid_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_from_free;
  logic                 r_gnt;

  logic [ENTRY_NUM-1:0] w_free;
  logic [ENTRY_NUM-1:0] w_free_1h;
  logic                 w_any_free;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_take;
  logic                 w_commit;
  logic                 w_busy;
  logic [IDX_W:0]       w_free_cnt;

  // Lowest invalid entry: isolate the least significant set bit, then encode.
  always_comb begin
    w_free     = ~r_valid;
    w_free_1h  = w_free & (~w_free + 1'b1);
    w_any_free = |w_free;
    w_free_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (w_free_1h[i]) w_free_idx = w_free_idx | IDX_W'(i);
    end
  end

  assign w_take   = (r_state == IDLE) && bus.alloc_req;
  assign w_commit = (r_state == WAIT) && bus.alloc_commit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; commit and cancel both release the reservation
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.alloc_req) w_state_nxt = WAIT;
      WAIT:    if (bus.alloc_commit || bus.alloc_cancel) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = (r_state == WAIT);
  end

  // Grant pulse and the held selection result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt       <= 1'b0;
      r_idx       <= '0;
      r_from_free <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_gnt <= w_take;
      if (w_take) begin
        r_from_free <= w_any_free;
        if (w_any_free) begin
          r_idx <= w_free_idx;
        end else begin
          r_idx    <= r_rr_ptr;
          r_rr_ptr <= r_rr_ptr + 1'b1;
        end
      end
    end
  end

  // Per-entry update: inv_all > inv_en > wr_en > commit of the reserved entry
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (bus.inv_all)                                  w_valid_nxt[i] = 1'b0;
      else if (bus.inv_en && (bus.inv_idx == IDX_W'(i))) w_valid_nxt[i] = 1'b0;
      else if (bus.wr_en && (bus.wr_idx == IDX_W'(i)))   w_valid_nxt[i] = bus.wr_e;
      else if (w_commit && (r_idx == IDX_W'(i)))         w_valid_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_valid <= '0;
    else       r_valid <= w_valid_nxt;
  end

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_free_cnt = w_free_cnt + (IDX_W+1)'(~r_valid[i]);
    end
  end

  assign bus.alloc_gnt       = r_gnt;
  assign bus.alloc_idx       = r_idx;
  assign bus.alloc_from_free = r_from_free;
  assign bus.busy            = w_busy;
  assign bus.valid_vec       = r_valid;
  assign bus.free_cnt        = w_free_cnt;

endmodule
